// File: rtl/dcache_write_stage.sv
// dcache_write_stage: final stage of the dcache pipeline. It takes one request at a
// time from the request arbiter. A refill into a dirty way first reads the victim
// line and bursts it to memory as four beats, then installs the new line. A store
// hit merges the store bytes into the line and writes it back as dirty. Each request
// ends with a completion response.
// Optional build macro: DCACHE_WRITE_STAGE_PERF_EN adds the io_perf_wbLines and
// io_perf_stores event counters.
module dcache_write_stage #(
  parameter int unsigned TAG_W = 19,
  parameter int unsigned SET_W = 9,
  parameter int unsigned WORDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic             io_in_ready,
  input  logic             io_in_valid,
  input  logic [31:0]      io_in_bits_addr,
  input  logic             io_in_bits_dirInfo_hit,
  input  logic [3:0]       io_in_bits_dirInfo_chosenWay,
  input  logic             io_in_bits_dirInfo_isDirtyWay,
  input  logic [TAG_W-1:0] io_in_bits_dirtyTag,
  input  logic [31:0]      io_in_bits_data_0,
  input  logic [31:0]      io_in_bits_data_1,
  input  logic [31:0]      io_in_bits_data_2,
  input  logic [31:0]      io_in_bits_data_3,
  input  logic             io_in_bits_isStore,
  input  logic [31:0]      io_in_bits_storeData,
  input  logic [3:0]       io_in_bits_storeMask,
  output logic             io_vRead_valid,
  output logic [SET_W-1:0] io_vRead_set,
  output logic [3:0]       io_vRead_way,
  input  logic [31:0]      io_vRead_data_0,
  input  logic [31:0]      io_vRead_data_1,
  input  logic [31:0]      io_vRead_data_2,
  input  logic [31:0]      io_vRead_data_3,
  output logic             io_wb_valid,
  input  logic             io_wb_ready,
  output logic [31:0]      io_wb_addr,
  output logic [1:0]       io_wb_beat,
  output logic [31:0]      io_wb_data,
  output logic             io_wb_last,
  output logic             io_arrWrite_valid,
  output logic [SET_W-1:0] io_arrWrite_set,
  output logic [3:0]       io_arrWrite_way,
  output logic [TAG_W-1:0] io_arrWrite_tag,
  output logic             io_arrWrite_dirty,
  output logic [31:0]      io_arrWrite_data_0,
  output logic [31:0]      io_arrWrite_data_1,
  output logic [31:0]      io_arrWrite_data_2,
  output logic [31:0]      io_arrWrite_data_3,
`ifdef DCACHE_WRITE_STAGE_PERF_EN
  output logic [31:0]      io_perf_wbLines,
  output logic [31:0]      io_perf_stores,
`endif
  output logic             io_resp_valid,
  input  logic             io_resp_ready,
  output logic             io_resp_dropped
);

  typedef enum logic [2:0] {IDLE, VREAD, VCAP, WB, WRITE, RESP} state_t;

  state_t             state;
  logic [1:0]         beat;
  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [3:0]         way_q;
  logic [TAG_W-1:0]   dirty_tag_q;
  logic               is_store_q;
  logic               hit_q;
  logic [31:0]        arr_data_q [WORDS];
  logic [31:0]        wb_buf [WORDS];
  logic [31:0]        in_line [WORDS];
  logic [31:0]        vr_line [WORDS];

  logic               in_ready_q;
  logic               vread_valid_q;
  logic               wb_valid_q;
  logic               wb_last_q;
  logic [31:0]        wb_data_q;
  logic               arr_valid_q;
  logic               arr_dirty_q;
  logic               resp_valid_q;
  logic               resp_dropped_q;

  // Byte offset within a word never affects line data
  logic               unused_addr_bits;
  assign unused_addr_bits = ^io_in_bits_addr[1:0];

  assign in_line[0] = io_in_bits_data_0;
  assign in_line[1] = io_in_bits_data_1;
  assign in_line[2] = io_in_bits_data_2;
  assign in_line[3] = io_in_bits_data_3;
  assign vr_line[0] = io_vRead_data_0;
  assign vr_line[1] = io_vRead_data_1;
  assign vr_line[2] = io_vRead_data_2;
  assign vr_line[3] = io_vRead_data_3;

  // Byte-wise merge of store data into one word under the byte mask
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] st_w,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = st_w[8*b +: 8];
    end
    return r;
  endfunction

  // Request FSM with registered handshake and array/writeback outputs.
  // The line to install (store merge already applied) is formed on accept, so
  // the store data, mask and input line need not be held past that edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      beat           <= '0;
      tag_q          <= '0;
      set_q          <= '0;
      way_q          <= '0;
      dirty_tag_q    <= '0;
      is_store_q     <= 1'b0;
      hit_q          <= 1'b0;
      for (int unsigned w = 0; w < WORDS; w++) begin
        arr_data_q[w] <= '0;
        wb_buf[w]     <= '0;
      end
      in_ready_q     <= 1'b1;
      vread_valid_q  <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_last_q      <= 1'b0;
      wb_data_q      <= '0;
      arr_valid_q    <= 1'b0;
      arr_dirty_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_dropped_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            tag_q       <= io_in_bits_addr[31 -: TAG_W];
            set_q       <= io_in_bits_addr[4 +: SET_W];
            way_q       <= io_in_bits_dirInfo_chosenWay;
            dirty_tag_q <= io_in_bits_dirtyTag;
            is_store_q  <= io_in_bits_isStore;
            hit_q       <= io_in_bits_dirInfo_hit;
            arr_dirty_q <= io_in_bits_isStore;
            for (int unsigned w = 0; w < WORDS; w++) begin
              if (io_in_bits_isStore && (io_in_bits_addr[3:2] == 2'(w)))
                arr_data_q[w] <= merge_word(in_line[w], io_in_bits_storeData,
                                            io_in_bits_storeMask);
              else
                arr_data_q[w] <= in_line[w];
            end
            in_ready_q <= 1'b0;
            if (!io_in_bits_isStore && io_in_bits_dirInfo_isDirtyWay) begin
              vread_valid_q <= 1'b1;
              state         <= VREAD;
            end else begin
              arr_valid_q <= !io_in_bits_isStore || io_in_bits_dirInfo_hit;
              state       <= WRITE;
            end
          end
        end
        VREAD: begin
          vread_valid_q <= 1'b0;
          state         <= VCAP;
        end
        VCAP: begin
          for (int unsigned w = 0; w < WORDS; w++) wb_buf[w] <= vr_line[w];
          wb_data_q  <= io_vRead_data_0;
          wb_valid_q <= 1'b1;
          wb_last_q  <= 1'b0;
          beat       <= '0;
          state      <= WB;
        end
        WB: begin
          if (io_wb_ready) begin
            beat      <= beat + 2'd1;
            wb_data_q <= wb_buf[beat + 2'd1];
            wb_last_q <= (beat == 2'd2);
            if (wb_last_q) begin
              wb_valid_q  <= 1'b0;
              wb_last_q   <= 1'b0;
              arr_valid_q <= 1'b1;
              state       <= WRITE;
            end
          end
        end
        WRITE: begin
          arr_valid_q    <= 1'b0;
          resp_valid_q   <= 1'b1;
          resp_dropped_q <= is_store_q && !hit_q;
          state          <= RESP;
        end
        RESP: begin
          if (io_resp_ready) begin
            resp_valid_q   <= 1'b0;
            resp_dropped_q <= 1'b0;
            in_ready_q     <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_WRITE_STAGE_PERF_EN
  logic [31:0] perf_wb_lines_q;
  logic [31:0] perf_stores_q;

  // Event counters: completed writeback lines and performed store writes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_wb_lines_q <= '0;
      perf_stores_q   <= '0;
    end else begin
      if ((state == WB) && io_wb_ready && wb_last_q)
        perf_wb_lines_q <= perf_wb_lines_q + 32'd1;
      if ((state == WRITE) && arr_valid_q && is_store_q)
        perf_stores_q <= perf_stores_q + 32'd1;
    end
  end

  assign io_perf_wbLines = perf_wb_lines_q;
  assign io_perf_stores  = perf_stores_q;
`endif

  assign io_in_ready        = in_ready_q;
  assign io_vRead_valid     = vread_valid_q;
  assign io_vRead_set       = set_q;
  assign io_vRead_way       = way_q;
  assign io_wb_valid        = wb_valid_q;
  assign io_wb_addr         = {dirty_tag_q, set_q, 4'h0};
  assign io_wb_beat         = beat;
  assign io_wb_data         = wb_data_q;
  assign io_wb_last         = wb_last_q;
  assign io_arrWrite_valid  = arr_valid_q;
  assign io_arrWrite_set    = set_q;
  assign io_arrWrite_way    = way_q;
  assign io_arrWrite_tag    = tag_q;
  assign io_arrWrite_dirty  = arr_dirty_q;
  assign io_arrWrite_data_0 = arr_data_q[0];
  assign io_arrWrite_data_1 = arr_data_q[1];
  assign io_arrWrite_data_2 = arr_data_q[2];
  assign io_arrWrite_data_3 = arr_data_q[3];
  assign io_resp_valid      = resp_valid_q;
  assign io_resp_dropped    = resp_dropped_q;

endmodule

// File: tb/tb_dcache_write_stage.sv
// Directed bench for dcache_write_stage with scoreboard queues for victim reads,
// writeback beats, array writes and responses, plus a small victim data-array model.
module tb_dcache_write_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_ready;
  logic        io_in_valid;
  logic [31:0] io_in_bits_addr;
  logic        io_in_bits_dirInfo_hit;
  logic [3:0]  io_in_bits_dirInfo_chosenWay;
  logic        io_in_bits_dirInfo_isDirtyWay;
  logic [18:0] io_in_bits_dirtyTag;
  logic [31:0] io_in_bits_data_0, io_in_bits_data_1, io_in_bits_data_2, io_in_bits_data_3;
  logic        io_in_bits_isStore;
  logic [31:0] io_in_bits_storeData;
  logic [3:0]  io_in_bits_storeMask;
  logic        io_vRead_valid;
  logic [8:0]  io_vRead_set;
  logic [3:0]  io_vRead_way;
  logic [31:0] io_vRead_data_0, io_vRead_data_1, io_vRead_data_2, io_vRead_data_3;
  logic        io_wb_valid;
  logic        io_wb_ready;
  logic [31:0] io_wb_addr;
  logic [1:0]  io_wb_beat;
  logic [31:0] io_wb_data;
  logic        io_wb_last;
  logic        io_arrWrite_valid;
  logic [8:0]  io_arrWrite_set;
  logic [3:0]  io_arrWrite_way;
  logic [18:0] io_arrWrite_tag;
  logic        io_arrWrite_dirty;
  logic [31:0] io_arrWrite_data_0, io_arrWrite_data_1, io_arrWrite_data_2, io_arrWrite_data_3;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic        io_resp_dropped;
`ifdef DCACHE_WRITE_STAGE_PERF_EN
  logic [31:0] io_perf_wbLines;
  logic [31:0] io_perf_stores;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0]       set;
    logic [3:0]       way;
    logic [18:0]      tag;
    logic             dirty;
    logic [3:0][31:0] d;
  } arr_t;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  beat;
    logic [31:0] data;
    logic        last;
  } beat_t;
  typedef struct {
    logic [8:0] set;
    logic [3:0] way;
  } vr_t;

  arr_t  arr_q[$];
  beat_t wb_q[$];
  vr_t   vr_q[$];
  logic  resp_q[$];

  logic [3:0][31:0] victim = {32'd4, 32'd3, 32'd2, 32'd1};
  logic vr_seen = 1'b0;
  logic wb_toggle = 1'b0;

  dcache_write_stage dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_ready                   (io_in_ready),
    .io_in_valid                   (io_in_valid),
    .io_in_bits_addr               (io_in_bits_addr),
    .io_in_bits_dirInfo_hit        (io_in_bits_dirInfo_hit),
    .io_in_bits_dirInfo_chosenWay  (io_in_bits_dirInfo_chosenWay),
    .io_in_bits_dirInfo_isDirtyWay (io_in_bits_dirInfo_isDirtyWay),
    .io_in_bits_dirtyTag           (io_in_bits_dirtyTag),
    .io_in_bits_data_0             (io_in_bits_data_0),
    .io_in_bits_data_1             (io_in_bits_data_1),
    .io_in_bits_data_2             (io_in_bits_data_2),
    .io_in_bits_data_3             (io_in_bits_data_3),
    .io_in_bits_isStore            (io_in_bits_isStore),
    .io_in_bits_storeData          (io_in_bits_storeData),
    .io_in_bits_storeMask          (io_in_bits_storeMask),
    .io_vRead_valid                (io_vRead_valid),
    .io_vRead_set                  (io_vRead_set),
    .io_vRead_way                  (io_vRead_way),
    .io_vRead_data_0               (io_vRead_data_0),
    .io_vRead_data_1               (io_vRead_data_1),
    .io_vRead_data_2               (io_vRead_data_2),
    .io_vRead_data_3               (io_vRead_data_3),
    .io_wb_valid                   (io_wb_valid),
    .io_wb_ready                   (io_wb_ready),
    .io_wb_addr                    (io_wb_addr),
    .io_wb_beat                    (io_wb_beat),
    .io_wb_data                    (io_wb_data),
    .io_wb_last                    (io_wb_last),
    .io_arrWrite_valid             (io_arrWrite_valid),
    .io_arrWrite_set               (io_arrWrite_set),
    .io_arrWrite_way               (io_arrWrite_way),
    .io_arrWrite_tag               (io_arrWrite_tag),
    .io_arrWrite_dirty             (io_arrWrite_dirty),
    .io_arrWrite_data_0            (io_arrWrite_data_0),
    .io_arrWrite_data_1            (io_arrWrite_data_1),
    .io_arrWrite_data_2            (io_arrWrite_data_2),
    .io_arrWrite_data_3            (io_arrWrite_data_3),
`ifdef DCACHE_WRITE_STAGE_PERF_EN
    .io_perf_wbLines               (io_perf_wbLines),
    .io_perf_stores                (io_perf_stores),
`endif
    .io_resp_valid                 (io_resp_valid),
    .io_resp_ready                 (io_resp_ready),
    .io_resp_dropped               (io_resp_dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Victim data array: line appears only in the cycle after a read strobe
  always @(negedge clock) vr_seen = io_vRead_valid;
  always @(posedge clock) begin
    #1;
    if (vr_seen) begin
      io_vRead_data_0 = victim[0];
      io_vRead_data_1 = victim[1];
      io_vRead_data_2 = victim[2];
      io_vRead_data_3 = victim[3];
    end else begin
      io_vRead_data_0 = 32'hDEAD_0000;
      io_vRead_data_1 = 32'hDEAD_0001;
      io_vRead_data_2 = 32'hDEAD_0002;
      io_vRead_data_3 = 32'hDEAD_0003;
    end
  end

  // Memory-side backpressure toggling when enabled
  always @(posedge clock) begin
    #1;
    if (wb_toggle) io_wb_ready = ~io_wb_ready;
  end

  // Scoreboard monitors, sampled mid-cycle
  always @(negedge clock) begin
    vr_t   ve;
    arr_t  ae;
    beat_t be;
    if (io_vRead_valid) begin
      check("vread_expected", 32'(vr_q.size() != 0), 32'd1);
      if (vr_q.size() != 0) begin
        ve = vr_q.pop_front();
        check("vread_set", 32'(io_vRead_set), 32'(ve.set));
        check("vread_way", 32'(io_vRead_way), 32'(ve.way));
      end
    end
    if (io_wb_valid) begin
      check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
      if (wb_q.size() != 0) begin
        be = wb_q[0];
        check("wb_addr", io_wb_addr, be.addr);
        check("wb_beat", 32'(io_wb_beat), 32'(be.beat));
        check("wb_data", io_wb_data, be.data);
        check("wb_last", 32'(io_wb_last), 32'(be.last));
        if (io_wb_ready) void'(wb_q.pop_front());
      end
    end
    if (io_arrWrite_valid) begin
      check("arr_expected", 32'(arr_q.size() != 0), 32'd1);
      if (arr_q.size() != 0) begin
        ae = arr_q.pop_front();
        check("arr_set", 32'(io_arrWrite_set), 32'(ae.set));
        check("arr_way", 32'(io_arrWrite_way), 32'(ae.way));
        check("arr_tag", 32'(io_arrWrite_tag), 32'(ae.tag));
        check("arr_dirty", 32'(io_arrWrite_dirty), 32'(ae.dirty));
        check("arr_d0", io_arrWrite_data_0, ae.d[0]);
        check("arr_d1", io_arrWrite_data_1, ae.d[1]);
        check("arr_d2", io_arrWrite_data_2, ae.d[2]);
        check("arr_d3", io_arrWrite_data_3, ae.d[3]);
      end
    end
    if (io_resp_valid) begin
      check("resp_expected", 32'(resp_q.size() != 0), 32'd1);
      if (resp_q.size() != 0) begin
        check("resp_dropped", 32'(io_resp_dropped), 32'(resp_q[0]));
        if (io_resp_ready) void'(resp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] addr, input logic hit, input logic [3:0] way,
                      input logic dirty_way, input logic [18:0] dtag,
                      input logic [31:0] l0, input logic [31:0] l1,
                      input logic [31:0] l2, input logic [31:0] l3,
                      input logic is_store, input logic [31:0] sd, input logic [3:0] sm);
    arr_t a;
    beat_t b;
    int unsigned n;
    n = 0;
    while (!io_in_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("in_ready_wait", 32'(io_in_ready), 32'd1);
    a.set = addr[12:4];
    a.way = way;
    a.tag = addr[31:13];
    a.dirty = is_store;
    a.d = {l3, l2, l1, l0};
    if (is_store)
      for (int i = 0; i < 4; i++)
        if (sm[i]) a.d[addr[3:2]][8*i +: 8] = sd[8*i +: 8];
    if (!is_store || hit) arr_q.push_back(a);
    resp_q.push_back(is_store && !hit);
    if (!is_store && dirty_way) begin
      vr_q.push_back('{set: addr[12:4], way: way});
      for (int i = 0; i < 4; i++) begin
        b.addr = {dtag, addr[12:4], 4'h0};
        b.beat = 2'(i);
        b.data = victim[i];
        b.last = (i == 3);
        wb_q.push_back(b);
      end
    end
    io_in_bits_addr = addr;
    io_in_bits_dirInfo_hit = hit;
    io_in_bits_dirInfo_chosenWay = way;
    io_in_bits_dirInfo_isDirtyWay = dirty_way;
    io_in_bits_dirtyTag = dtag;
    io_in_bits_data_0 = l0;
    io_in_bits_data_1 = l1;
    io_in_bits_data_2 = l2;
    io_in_bits_data_3 = l3;
    io_in_bits_isStore = is_store;
    io_in_bits_storeData = sd;
    io_in_bits_storeMask = sm;
    io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (!io_in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check(tag, 32'(io_in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    io_in_valid = 1'b0;
    io_in_bits_addr = '0;
    io_in_bits_dirInfo_hit = 1'b0;
    io_in_bits_dirInfo_chosenWay = '0;
    io_in_bits_dirInfo_isDirtyWay = 1'b0;
    io_in_bits_dirtyTag = '0;
    io_in_bits_data_0 = '0;
    io_in_bits_data_1 = '0;
    io_in_bits_data_2 = '0;
    io_in_bits_data_3 = '0;
    io_in_bits_isStore = 1'b0;
    io_in_bits_storeData = '0;
    io_in_bits_storeMask = '0;
    io_wb_ready = 1'b1;
    io_resp_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(io_in_ready), 32'd1);
    check("rst_vread", 32'(io_vRead_valid), 32'd0);
    check("rst_wb_valid", 32'(io_wb_valid), 32'd0);
    check("rst_wb_beat", 32'(io_wb_beat), 32'd0);
    check("rst_arr_valid", 32'(io_arrWrite_valid), 32'd0);
    check("rst_resp_valid", 32'(io_resp_valid), 32'd0);
    check("rst_dropped", 32'(io_resp_dropped), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Store hit into word 2, bytes 0 and 2
    send(32'h0000_1238, 1'b1, 4'b0010, 1'b0, 19'h0,
         32'h1111_0000, 32'h2222_0000, 32'hAABB_CCDD, 32'h4444_0000,
         1'b1, 32'h1122_3344, 4'b0101);
    check("st_arr_lat", 32'(io_arrWrite_valid), 32'd1);
    check("st_arr_d2", io_arrWrite_data_2, 32'hAA22_CC44);
    check("st_arr_set", 32'(io_arrWrite_set), 32'h123);
    check("st_in_ready", 32'(io_in_ready), 32'd0);
    @(posedge clock); #1;
    check("st_resp_lat", 32'(io_resp_valid), 32'd1);
    check("st_arr_done", 32'(io_arrWrite_valid), 32'd0);
    wait_idle("st_done");

    // Clean refill at the top of the address space
    send(32'hFFFF_E000, 1'b0, 4'b1000, 1'b0, 19'h0,
         32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
         1'b0, 32'h0, 4'h0);
    check("cr_arr_lat", 32'(io_arrWrite_valid), 32'd1);
    check("cr_arr_tag", 32'(io_arrWrite_tag), 32'h7FFFF);
    check("cr_no_vread", 32'(io_vRead_valid), 32'd0);
    @(posedge clock); #1;
    check("cr_resp_lat", 32'(io_resp_valid), 32'd1);
    check("cr_no_wb", 32'(io_wb_valid), 32'd0);
    wait_idle("cr_done");

    // Dirty refill with toggling writeback backpressure
    wb_toggle = 1'b1;
    send(32'h0157_9FF0, 1'b0, 4'b0100, 1'b1, 19'h12345,
         32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003,
         1'b0, 32'h0, 4'h0);
    check("dr_vread", 32'(io_vRead_valid), 32'd1);
    n = 0;
    while (!io_wb_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("dr_wb_start", 32'(io_wb_valid), 32'd1);
    check("dr_wb_addr", io_wb_addr, 32'h2468_BFF0);
    wait_idle("dr_done");
    wb_toggle = 1'b0;
    io_wb_ready = 1'b1;

    // Dirty refill with no stall: write at T+7, response at T+8
    send(32'h0000_0040, 1'b0, 4'b0001, 1'b1, 19'h00007,
         32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003,
         1'b0, 32'h0, 4'h0);
    check("lat_vread_t1", 32'(io_vRead_valid), 32'd1);
    @(posedge clock); #1;
    check("lat_vread_t2", 32'(io_vRead_valid), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    check("lat_last_t6", 32'(io_wb_last), 32'd1);
    check("lat_arr_t6", 32'(io_arrWrite_valid), 32'd0);
    @(posedge clock); #1;
    check("lat_arr_t7", 32'(io_arrWrite_valid), 32'd1);
    check("lat_wb_t7", 32'(io_wb_valid), 32'd0);
    @(posedge clock); #1;
    check("lat_resp_t8", 32'(io_resp_valid), 32'd1);
    wait_idle("lat_done");

    // Store hit with empty mask: line unchanged but marked dirty
    send(32'h0000_0004, 1'b1, 4'b0001, 1'b0, 19'h0,
         32'h7000_0000, 32'h7000_0001, 32'h7000_0002, 32'h7000_0003,
         1'b1, 32'hFFFF_FFFF, 4'h0);
    wait_idle("m0_done");

    // Store miss held in RESP by a stalled consumer
    io_resp_ready = 1'b0;
    send(32'h0000_2000, 1'b0, 4'b0010, 1'b0, 19'h0,
         32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003,
         1'b1, 32'h1234_5678, 4'hF);
    check("miss_no_arr", 32'(io_arrWrite_valid), 32'd0);
    @(posedge clock); #1;
    for (int c = 0; c < 5; c++) begin
      check("hold_resp_valid", 32'(io_resp_valid), 32'd1);
      check("hold_dropped", 32'(io_resp_dropped), 32'd1);
      check("hold_in_ready", 32'(io_in_ready), 32'd0);
      @(posedge clock); #1;
    end
    io_resp_ready = 1'b1;
    wait_idle("miss_done");

    // Reset while beat 2 of a writeback is pending
    send(32'h0000_0100, 1'b0, 4'b0100, 1'b1, 19'h00055,
         32'h9000_0000, 32'h9000_0001, 32'h9000_0002, 32'h9000_0003,
         1'b0, 32'h0, 4'h0);
    n = 0;
    while (!(io_wb_valid && io_wb_beat == 2'd2) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    io_wb_ready = 1'b0;
    check("rb_reach_beat2", 32'(io_wb_beat), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("rb_wb_drop", 32'(io_wb_valid), 32'd0);
    check("rb_in_ready", 32'(io_in_ready), 32'd1);
    wb_q.delete();
    arr_q.delete();
    resp_q.delete();
    vr_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    io_wb_ready = 1'b1;
    @(posedge clock); #1;
    check("rb_idle_ready", 32'(io_in_ready), 32'd1);
    check("rb_idle_beat", 32'(io_wb_beat), 32'd0);
    check("rb_idle_wb", 32'(io_wb_valid), 32'd0);
    send(32'h0000_0038, 1'b1, 4'b1000, 1'b0, 19'h0,
         32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
         1'b1, 32'hCAFE_F00D, 4'b1100);
    check("rb_st_arr", 32'(io_arrWrite_valid), 32'd1);
    wait_idle("rb_st_done");

    repeat (3) @(posedge clock);
    #1;
    check("end_arr_q", 32'(arr_q.size()), 32'd0);
    check("end_wb_q", 32'(wb_q.size()), 32'd0);
    check("end_resp_q", 32'(resp_q.size()), 32'd0);
    check("end_vr_q", 32'(vr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_write_stage.md
Name: dcache_write_stage

Overview:
- Sits directly downstream of the dcache request arbiter and consumes its single output stream: refill requests (isStore=0) or store hits (isStore=1).
- For a refill whose chosen way is dirty, it reads the victim line, bursts it to memory as 4 beats, then installs the new line.
- For a store, it merges store bytes into the line and writes it back as dirty.
- Processes one request at a time and returns a completion response.

Parameters:
- TAG_W, 19, tag width; addr[31:13]
- SET_W, 9, set index width; addr[12:4]
- WORDS, 4, 32-bit words per line; word select addr[3:2]

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- io_in_ready  out  1  stage accepts a request
- io_in_valid  in  1  request valid
- io_in_bits_addr  in  32  request address
- io_in_bits_dirInfo_hit  in  1  directory hit
- io_in_bits_dirInfo_chosenWay  in  4  one-hot target way
- io_in_bits_dirInfo_isDirtyWay  in  1  target way holds a dirty line
- io_in_bits_dirtyTag  in  19  tag of the dirty victim
- io_in_bits_data_0..3  in  32 each  refill line (refill) or current hit line (store)
- io_in_bits_isStore  in  1  store request
- io_in_bits_storeData  in  32  store data
- io_in_bits_storeMask  in  4  byte enables
- io_vRead_valid  out  1  victim data-array read strobe
- io_vRead_set  out  9  read set
- io_vRead_way  out  4  read way, one-hot
- io_vRead_data_0..3  in  32 each  victim data; valid exactly 1 cycle after the strobe
- io_wb_valid  out  1  writeback beat valid
- io_wb_ready  in  1  memory accepts the beat
- io_wb_addr  out  32  line base {dirtyTag,set,4'h0}, constant across the burst
- io_wb_beat  out  2  beat index
- io_wb_data  out  32  beat data
- io_wb_last  out  1  final beat (beat 3)
- io_arrWrite_valid  out  1  data/dir array write strobe, single cycle, always accepted
- io_arrWrite_set  out  9  write set
- io_arrWrite_way  out  4  write way
- io_arrWrite_tag  out  19  tag to install
- io_arrWrite_dirty  out  1  dirty bit to install
- io_arrWrite_data_0..3  out  32 each  line to write
- io_resp_valid  out  1  request complete
- io_resp_ready  in  1  response consumed
- io_resp_dropped  out  1  store missed; no write was performed

Behaviour:
- States: IDLE, VREAD, VCAP, WB, WRITE, RESP.
- Reset (asynchronous, active-low):
  - Enter IDLE; the beat counter clears to 0.
  - All outputs are 0 except io_in_ready, which is 1.
  - Reset asserted mid-burst drops io_wb_valid immediately. The line is not resumed.
- IDLE:
  - io_in_ready=1.
  - On fire, latch every io_in_bits field.
  - Next state: VREAD if isStore=0 and isDirtyWay=1; otherwise WRITE.
  - io_in_ready=0 in every other state, so there is no same-cycle accept on completion.
- VREAD (1 cycle):
  - io_vRead_valid=1, set=addr[12:4], way=chosenWay.
  - Next state: VCAP.
- VCAP (1 cycle):
  - Latch io_vRead_data_0..3 into the writeback buffer.
  - Next state: WB with beat=0.
- WB:
  - io_wb_valid=1, io_wb_data=buffer[beat], io_wb_last=(beat==3).
  - On io_wb_ready, beat increments.
  - On the accepted last beat, go to WRITE. Beat wraps to 0.
  - Beat data and address hold stable while ready is low.
- WRITE (1 cycle):
  - io_arrWrite_valid=1, set=addr[12:4], way=chosenWay, tag=addr[31:13].
  - Refill: data = latched line, dirty=0.
  - Store with hit=1: word addr[3:2] is merged byte-wise; byte i takes storeData byte i when mask[i]=1, otherwise the old byte. Other words pass unchanged. dirty=1.
  - mask=4'h0: line is written unchanged with dirty=1.
  - Store with hit=0: io_arrWrite_valid stays 0 and a dropped flag is set.
  - Next state: RESP.
- RESP:
  - io_resp_valid=1, io_resp_dropped=dropped flag.
  - Hold until io_resp_ready. Next state: IDLE and the flag clears.
- Latency:
  - Clean refill or store: accept at T, array write T+1, resp T+2.
  - Dirty refill: write at T+7 with zero wb stall; resp T+8.

Optional Feature:
- Macro DCACHE_WRITE_STAGE_PERF_EN.
- When defined, adds outputs io_perf_wbLines (32) and io_perf_stores (32).
  - io_perf_wbLines increments on each accepted io_wb_last beat.
  - io_perf_stores increments on each store array write.
  - Both wrap at 2^32 and clear on reset.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store hit, addr=0x0000_1238, data_2=0xAABBCCDD, storeData=0x11223344, mask=4'b0101, chosenWay=4'b0010 -> T+1: arrWrite set=0x123, way=2, tag=0x0, data_2=0xAA22CC44, dirty=1; T+2: resp_valid, dropped=0.
- Clean refill, addr=0xFFFF_E000, isDirtyWay=0 -> no vRead, no wb beats; arrWrite tag=0x7FFFF, set=0, dirty=0, data equals input line.
- Dirty refill, dirtyTag=0x12345, set=0x1FF, vRead_data={1,2,3,4}, wb_ready toggling 1/0 -> vRead strobe once; wb_addr=0x2468_BFF0; beats 0..3 carry 1,2,3,4; last only on beat 3; arrWrite follows the final beat.
- Store with hit=0 -> no arrWrite; resp_valid with dropped=1.
- io_resp_ready held 0 for 5 cycles -> resp_valid and dropped held stable; io_in_ready=0 throughout.
- Reset asserted during WB beat 2 -> io_wb_valid=0 asynchronously; after release the block is in IDLE with io_in_ready=1, and a new request completes normally.
